// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end feeding decode.
// Issues reads to a 1-cycle synchronous instruction ROM. Returning words are
// buffered with their PCs in a 2-entry skid FIFO and presented to decode over
// valid/ready. Redirects from execute flush the FIFO. An epoch bit tags each
// fetch so that responses issued before a redirect are dropped.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target raises a sticky misalign_fault and
//               halts fetch until an aligned redirect or reset.
//   undefined : redirect_pc[1:0] are ignored and misalign_fault is tied 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_addr/en      ROM byte address (= pc) and read enable
//   imem_dout         ROM read data, valid the cycle after imem_en
//   out_valid/ready   handshake to decode
//   out_pc/out_instr  head-of-FIFO {pc, instr} pair
//   redirect_valid/pc PC change request from execute
//   misalign_fault    sticky misaligned-redirect flag (trap build only)
module fetch_stage #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_en,
    input  logic [XLEN-1:0] imem_dout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misalign_fault
);

    localparam int unsigned OCC_W = 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            epoch;
    logic            req_epoch;
    entry_t          fifo [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;

    logic             pop_c;
    logic             push_c;
    logic [OCC_W-1:0] occ_c;
    logic [XLEN-1:0]  redirect_tgt_c;

    // Misaligned-target handling: trap and halt, or silently align.
`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= |redirect_pc[1:0];
        end
    end

    assign misalign_fault = fault_q;
    assign redirect_tgt_c = redirect_pc;
`else
    assign misalign_fault = 1'b0;
    assign redirect_tgt_c = redirect_pc & ~XLEN'(3);
`endif

    // Occupancy counts the inflight fetch as already buffered, so a push
    // always finds a free slot (a same-cycle pop frees one in advance).
    assign pop_c  = out_valid & out_ready;
    assign occ_c  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop_c);
    assign push_c = inflight & (req_epoch == epoch) & ~redirect_valid;

    // rst_n gates the enable so the ROM sees no read while reset is asserted.
    assign imem_en   = rst_n & ~redirect_valid & ~misalign_fault
                     & (occ_c < OCC_W'(FIFO_DEPTH));
    assign imem_addr = pc;

    assign out_valid = (count != 2'd0) & ~misalign_fault;
    assign out_pc    = fifo[rd_ptr].pc;
    assign out_instr = fifo[rd_ptr].instr;

    // PC, request tracking and skid FIFO state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            req_pc    <= '0;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc       <= redirect_tgt_c;
            epoch    <= ~epoch;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                req_pc    <= pc;
                req_epoch <= epoch;
                pc        <= pc + XLEN'(4);
            end
            if (push_c) begin
                fifo[wr_ptr] <= '{pc: req_pc, instr: imem_dout};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push_c) - 2'(pop_c);
        end
    end

    // A push into a full FIFO without a simultaneous pop would lose data.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push_c && (count == 2'd2) && !pop_c));

endmodule
